// File: rtl/ej32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ej32_pkg                                                             |
// | Shared types and beat-geometry helpers for the eJ32 load/store unit.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ej32_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_GET   = 2'd2,
    OP_PUT   = 2'd3
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Bus beats needed for a 2**lgsz byte access; narrow accesses take one beat.
  function automatic logic [2:0] nbeats(input logic [1:0] lgsz, input int bus_bytes);
    int sz;
    sz = 1 << lgsz;
    if (sz > bus_bytes) return 3'(sz / bus_bytes);
    return 3'd1;
  endfunction

  // Byte enables for one beat; bit bus_bytes-1 is the lowest byte address.
  function automatic logic [3:0] be_mask(input logic [1:0] addr_lo, input logic [1:0] lgsz,
                                         input int bus_bytes);
    int sz;
    int o;
    sz = 1 << lgsz;
    o  = int'(addr_lo) % bus_bytes;
    if (sz >= bus_bytes) return 4'((1 << bus_bytes) - 1);
    return 4'(((1 << sz) - 1) << (bus_bytes - o - sz));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ej32_ring_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ej32_ring_ptr                                                        |
// | Console ring pointer: fixed base, 2**BUF_LG byte window, wraps on inc.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ej32_ring_ptr #(
  parameter int ASZ    = 17,
  parameter int BASE   = 'h1000,
  parameter int BUF_LG = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  output logic [ASZ-1:0] ptr
);

  localparam logic [ASZ-1:0] c_base = ASZ'(BASE);

  logic [BUF_LG-1:0] r_off;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_off <= '0;
    end else if (inc) begin
      r_off <= r_off + BUF_LG'(1);
    end
  end

  assign ptr = {c_base[ASZ-1:BUF_LG], r_off};

endmodule
`default_nettype wire

// File: rtl/ej32_lsu_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ej32_lsu_gen                                                         |
// | Big-endian load/store/get/put sequencer for a 1/2/4 byte memory bus.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ej32_lsu_gen
  import ej32_pkg::*;
#(
  parameter int DSZ       = 32,
  parameter int ASZ       = 17,
  parameter int BUS_BYTES = 1,
  parameter int TIB       = 'h1000,
  parameter int OBUF      = 'h1400,
  parameter int BUF_LG    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [1:0]             req_lgsz,
  input  logic                   req_sext,
  input  logic [ASZ-1:0]         req_addr,
  input  logic [DSZ-1:0]         req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [DSZ-1:0]         rsp_rdata,
  output logic [ASZ-1:0]         mem_addr,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [BUS_BYTES-1:0]   mem_be,
  output logic [8*BUS_BYTES-1:0] mem_wdata,
  input  logic [8*BUS_BYTES-1:0] mem_rdata,
  output logic [ASZ-1:0]         ibuf_ptr,
  output logic [ASZ-1:0]         obuf_ptr
);

  localparam int             c_bw        = 8 * BUS_BYTES;
  localparam logic [3:0]     c_bus       = 4'(BUS_BYTES);
  localparam logic [1:0]     c_lane_mask = 2'(BUS_BYTES - 1);
  localparam logic [ASZ-1:0] c_align     = ~ASZ'(BUS_BYTES - 1);

  lsu_state_t     r_state, w_next;
  lsu_op_t        r_op, w_op;
  logic [1:0]     r_lgsz, w_lgsz, r_addr_lo;
  logic           r_sext, r_err, r_rd_pend;
  logic           w_accept, w_ring, w_err, w_read, w_rd_beat, w_sign;
  logic [ASZ-1:0] r_baddr, w_addr;
  logic [2:0]     r_left;
  logic [DSZ-1:0] r_sdata, r_acc, w_sdata, w_lane, w_ext, w_szmask;
  logic [3:0]     w_sz, w_bb, w_off;
  logic [c_bw-1:0] w_rd_shift, w_bmask;

  // Command decode; GET/PUT become byte accesses at the current ring pointer.
  always_comb begin
    w_op     = lsu_op_t'(req_op);
    w_accept = req_valid && req_ready;
    w_ring   = (w_op == OP_GET) || (w_op == OP_PUT);
    w_lgsz   = w_ring ? 2'd0 : req_lgsz;
    w_addr   = req_addr;
    if (w_op == OP_GET)      w_addr = ibuf_ptr;
    else if (w_op == OP_PUT) w_addr = obuf_ptr;
    w_err = 1'b0;
    if (!w_ring) begin
      case (req_lgsz)
        2'd1:    w_err = req_addr[0];
        2'd2:    w_err = |req_addr[1:0];
        2'd3:    w_err = 1'b1;
        default: w_err = 1'b0;
      endcase
    end
    w_sdata = req_wdata << (DSZ - (8 << w_lgsz));
  end

  // Per-beat lane geometry: w_bb bytes starting at lane offset w_off.
  always_comb begin
    w_sz       = 4'd1 << r_lgsz;
    w_bb       = (w_sz < c_bus) ? w_sz : c_bus;
    w_off      = (w_sz < c_bus) ? 4'(r_addr_lo & c_lane_mask) : 4'd0;
    w_rd_shift = mem_rdata >> (8 * (BUS_BYTES - int'(w_off) - int'(w_bb)));
    w_bmask    = {c_bw{1'b1}} >> (c_bw - 8 * int'(w_bb));
    w_lane     = DSZ'(w_rd_shift & w_bmask);
    case (r_lgsz)
      2'd0: begin w_sign = r_acc[7];  w_szmask = DSZ'({8{1'b1}});  end
      2'd1: begin w_sign = r_acc[15]; w_szmask = DSZ'({16{1'b1}}); end
      default: begin w_sign = r_acc[DSZ-1]; w_szmask = '1; end
    endcase
    w_ext = r_acc | ((r_sext && w_sign) ? ~w_szmask : '0);
  end

  always_comb begin
    w_read = (r_op == OP_LOAD) || (r_op == OP_GET);
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_err ? ST_RESP : ST_BEAT;
      ST_BEAT:  if (r_left == 3'd1) w_next = w_read ? ST_DRAIN : ST_RESP;
      ST_DRAIN: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_LOAD;
      r_lgsz    <= 2'd0;
      r_addr_lo <= 2'd0;
      r_sext    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_pend <= 1'b0;
      r_baddr   <= '0;
      r_left    <= 3'd0;
      r_sdata   <= '0;
      r_acc     <= '0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= w_rd_beat;
      if (w_accept) begin
        r_op      <= w_op;
        r_lgsz    <= w_lgsz;
        r_addr_lo <= w_addr[1:0];
        r_sext    <= req_sext && (w_op == OP_LOAD);
        r_err     <= w_err;
        r_baddr   <= w_addr & c_align;
        r_left    <= nbeats(w_lgsz, BUS_BYTES);
        r_sdata   <= w_sdata;
        r_acc     <= '0;
      end else if (r_state == ST_BEAT) begin
        r_baddr <= r_baddr + ASZ'(BUS_BYTES);
        r_left  <= r_left - 3'd1;
        r_sdata <= r_sdata << c_bw;
      end
      // Read data lands one cycle after its beat; append it below earlier bytes.
      if (r_rd_pend) r_acc <= (r_acc << (8 * int'(w_bb))) | w_lane;
    end
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    mem_en    = (r_state == ST_BEAT);
    mem_we    = mem_en && !w_read;
    mem_be    = mem_en ? BUS_BYTES'(be_mask(r_addr_lo, r_lgsz, BUS_BYTES)) : '0;
    mem_addr  = r_baddr;
    mem_wdata = r_sdata[DSZ-1 -: c_bw] >> (8 * int'(w_off));
    w_rd_beat = mem_en && w_read;
    rsp_valid = (r_state == ST_RESP);
    rsp_err   = rsp_valid && r_err;
    rsp_rdata = (rsp_valid && w_read && !r_err) ? w_ext : '0;
  end

  ej32_ring_ptr #(.ASZ(ASZ), .BASE(TIB), .BUF_LG(BUF_LG)) u_ibuf (
    .clk (clk),
    .rst (rst),
    .inc (rsp_valid && !r_err && (r_op == OP_GET)),
    .ptr (ibuf_ptr)
  );

  ej32_ring_ptr #(.ASZ(ASZ), .BASE(OBUF), .BUF_LG(BUF_LG)) u_obuf (
    .clk (clk),
    .rst (rst),
    .inc (rsp_valid && !r_err && (r_op == OP_PUT)),
    .ptr (obuf_ptr)
  );

endmodule
`default_nettype wire

// File: tb/tb_ej32_lsu_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ej32_lsu_gen                                                      |
// | Three LSU instances (1/2/4 byte bus) against a byte-array model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ej32_lsu_gen;

  localparam int NI   = 3;
  localparam int TIB  = 'h1000;
  localparam int OBUF = 'h1400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a       [NI];
  logic        req_valid_a [NI];
  logic [1:0]  req_op_a    [NI];
  logic [1:0]  req_lgsz_a  [NI];
  logic        req_sext_a  [NI];
  logic [16:0] req_addr_a  [NI];
  logic [31:0] req_wdata_a [NI];
  logic [31:0] rdata_a     [NI];
  logic        ready_a     [NI];
  logic        rsp_valid_a [NI];
  logic        rsp_err_a   [NI];
  logic [31:0] rsp_rdata_a [NI];
  logic [16:0] addr_a      [NI];
  logic        en_a        [NI];
  logic        we_a        [NI];
  logic [3:0]  be_a        [NI];
  logic [31:0] wdata_a     [NI];
  logic [16:0] ibuf_a      [NI];
  logic [16:0] obuf_a      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BB = 1 << g;
    logic [BB-1:0]   be;
    logic [8*BB-1:0] wd;
    ej32_lsu_gen #(.DSZ(32), .ASZ(17), .BUS_BYTES(BB), .TIB(TIB), .OBUF(OBUF),
                   .BUF_LG(g == 0 ? 2 : 10)) u_dut (
      .clk(clk), .rst(rst_a[g]),
      .req_valid(req_valid_a[g]), .req_ready(ready_a[g]),
      .req_op(req_op_a[g]), .req_lgsz(req_lgsz_a[g]), .req_sext(req_sext_a[g]),
      .req_addr(req_addr_a[g]), .req_wdata(req_wdata_a[g]),
      .rsp_valid(rsp_valid_a[g]), .rsp_err(rsp_err_a[g]), .rsp_rdata(rsp_rdata_a[g]),
      .mem_addr(addr_a[g]), .mem_en(en_a[g]), .mem_we(we_a[g]), .mem_be(be),
      .mem_wdata(wd), .mem_rdata(rdata_a[g][8*BB-1:0]),
      .ibuf_ptr(ibuf_a[g]), .obuf_ptr(obuf_a[g])
    );
    assign be_a[g]    = 4'(be);
    assign wdata_a[g] = 32'(wd);
  end

  logic [7:0] mem [0:(1<<17)-1];
  int ptr_i [NI];
  int ptr_o [NI];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ring_size(input int i);
    return (i == 0) ? 4 : 1024;
  endfunction

  // Issue one command on instance i and check every beat and the response.
  task automatic do_cmd(input int i, input int op, input int lg, input int sx,
                        input int a, input logic [31:0] wd);
    int bb, sz, nb, lat, rd, ring, err, a_eff, beats, done;
    logic [31:0] exp_rd, pword;
    logic [63:0] m;
    logic [3:0]  exp_be;
    logic        pend;
    bb    = 1 << i;
    ring  = (op >= 2);
    a_eff = (op == 2) ? ptr_i[i] : (op == 3) ? ptr_o[i] : a;
    sz    = ring ? 1 : (1 << lg);
    rd    = (op == 0 || op == 2);
    err   = !ring && (lg == 3 || (a % sz) != 0);
    nb    = err ? 0 : ((sz > bb) ? sz / bb : 1);
    lat   = err ? 1 : (rd ? nb + 2 : nb + 1);
    exp_rd = 32'd0;
    if (rd && !err) begin
      for (int b = 0; b < sz; b++) exp_rd = (exp_rd << 8) | 32'(mem[(a_eff + b) & 'h1FFFF]);
      m = (64'd1 << (8 * sz)) - 64'd1;
      if (sx != 0 && op == 0 && exp_rd[8*sz-1]) exp_rd = exp_rd | ~m[31:0];
    end

    check("req_ready_idle", 64'(ready_a[i]), 64'd1);
    req_valid_a[i] = 1'b1;
    req_op_a[i]    = 2'(op);
    req_lgsz_a[i]  = 2'(lg);
    req_sext_a[i]  = 1'(sx);
    req_addr_a[i]  = 17'(a);
    req_wdata_a[i] = wd;
    @(posedge clk);
    @(negedge clk);
    // Keep garbage on the request side while busy; it must be ignored.
    req_op_a[i]    = 2'($urandom);
    req_lgsz_a[i]  = 2'($urandom);
    req_sext_a[i]  = 1'($urandom);
    req_addr_a[i]  = 17'($urandom);
    req_wdata_a[i] = $urandom;
    done = 0; beats = 0; pend = 1'b0; pword = 32'd0;
    for (int c = 1; c <= 20 && done == 0; c++) begin
      rdata_a[i] = pend ? pword : $urandom;
      pend = 1'b0;
      if (en_a[i] === 1'b1) begin
        int ba;
        ba = (a_eff & ~(bb - 1)) + beats * bb;
        check("mem_addr", 64'(addr_a[i]), 64'(ba & 'h1FFFF));
        check("mem_we", 64'(we_a[i]), 64'(rd == 0));
        exp_be = 4'd0;
        for (int j = 0; j < bb; j++)
          if (ba + j >= a_eff && ba + j < a_eff + sz) exp_be[bb-1-j] = 1'b1;
        check("mem_be", 64'(be_a[i]), 64'(exp_be));
        if (rd == 0) begin
          for (int j = 0; j < bb; j++)
            if (ba + j >= a_eff && ba + j < a_eff + sz)
              check("mem_wdata", 64'(wdata_a[i][8*(bb-1-j) +: 8]),
                    64'(8'(wd >> (8 * (sz - 1 - (ba + j - a_eff))))));
        end else begin
          pword = 32'd0;
          for (int j = 0; j < bb; j++) pword = (pword << 8) | 32'(mem[(ba + j) & 'h1FFFF]);
          pend = 1'b1;
        end
        beats++;
      end
      if (rsp_valid_a[i] === 1'b1) begin
        req_valid_a[i] = 1'b0;
        check("rsp_latency", 64'(c), 64'(lat));
        check("rsp_err", 64'(rsp_err_a[i]), 64'(err));
        check("rsp_rdata", 64'(rsp_rdata_a[i]), 64'(exp_rd));
        check("beat_count", 64'(beats), 64'(nb));
        done = 1;
      end
      @(negedge clk);
    end
    req_valid_a[i] = 1'b0;
    check("rsp_timeout", 64'(done), 64'd1);

    if (!err && !rd)
      for (int b = 0; b < sz; b++) mem[(a_eff + b) & 'h1FFFF] = 8'(wd >> (8 * (sz - 1 - b)));
    if (op == 2) ptr_i[i] = TIB + ((ptr_i[i] - TIB + 1) % ring_size(i));
    if (op == 3) ptr_o[i] = OBUF + ((ptr_o[i] - OBUF + 1) % ring_size(i));
    check("ibuf_ptr", 64'(ibuf_a[i]), 64'(ptr_i[i]));
    check("obuf_ptr", 64'(obuf_a[i]), 64'(ptr_o[i]));
  endtask

  initial begin
    int op, lg, sx, a;
    for (int i = 0; i < NI; i++) begin
      rst_a[i] = 1'b0; req_valid_a[i] = 1'b0; req_op_a[i] = 2'd0; req_lgsz_a[i] = 2'd0;
      req_sext_a[i] = 1'b0; req_addr_a[i] = 17'd0; req_wdata_a[i] = 32'd0; rdata_a[i] = 32'd0;
      ptr_i[i] = TIB; ptr_o[i] = OBUF;
    end
    for (int k = 0; k < (1 << 17); k++) mem[k] = 8'($urandom);
    mem['h100] = 8'h12; mem['h101] = 8'h34; mem['h102] = 8'h56; mem['h103] = 8'h78;
    mem['h200] = 8'h00; mem['h201] = 8'h00; mem['h202] = 8'h80; mem['h203] = 8'h01;

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_ready", 64'(ready_a[i]), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid_a[i]), 64'd0);
      check("rst_rsp_err", 64'(rsp_err_a[i]), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata_a[i]), 64'd0);
      check("rst_mem_en", 64'(en_a[i]), 64'd0);
      check("rst_mem_we", 64'(we_a[i]), 64'd0);
      check("rst_mem_be", 64'(be_a[i]), 64'd0);
      check("rst_ibuf", 64'(ibuf_a[i]), 64'(TIB));
      check("rst_obuf", 64'(obuf_a[i]), 64'(OBUF));
      rst_a[i] = 1'b1;
    end
    @(negedge clk);

    do_cmd(0, 0, 2, 0, 'h100, 32'd0);
    do_cmd(2, 0, 1, 1, 'h202, 32'd0);
    do_cmd(1, 1, 2, 0, 'h300, 32'hDEADBEEF);
    do_cmd(1, 0, 2, 0, 'h300, 32'd0);
    check("store_readback", 64'({mem['h300], mem['h301], mem['h302], mem['h303]}),
          64'h0000_0000_DEAD_BEEF);
    do_cmd(1, 0, 2, 0, 'h101, 32'd0);
    do_cmd(0, 0, 3, 0, 'h100, 32'd0);
    for (int k = 0; k < 5; k++) begin
      do_cmd(0, 3, 0, 0, 0, 32'h41 + 32'(k));
      if (k == 3) check("obuf_wrap", 64'(obuf_a[0]), 64'(OBUF));
    end
    check("put_bytes", 64'({mem['h1400], mem['h1401], mem['h1402], mem['h1403]}),
          64'h0000_0000_4542_4344);
    do_cmd(0, 2, 0, 0, 0, 32'd0);
    do_cmd(0, 2, 0, 0, 0, 32'd0);

    // Reset lands during beat 1 of a four-beat store on the byte bus.
    req_valid_a[0] = 1'b1; req_op_a[0] = 2'd1; req_lgsz_a[0] = 2'd2;
    req_addr_a[0] = 17'h500; req_wdata_a[0] = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    check("abort_beat0_en", 64'(en_a[0]), 64'd1);
    @(negedge clk);
    check("abort_beat1_addr", 64'(addr_a[0]), 64'h501);
    rst_a[0] = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 64'(en_a[0]), 64'd0);
    check("abort_mem_we", 64'(we_a[0]), 64'd0);
    check("abort_idle", 64'(ready_a[0]), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid_a[0]), 64'd0);
    check("abort_ibuf", 64'(ibuf_a[0]), 64'(TIB));
    check("abort_obuf", 64'(obuf_a[0]), 64'(OBUF));
    rst_a[0] = 1'b1;
    ptr_i[0] = TIB; ptr_o[0] = OBUF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_quiet_rsp", 64'(rsp_valid_a[0]), 64'd0);
      check("abort_quiet_en", 64'(en_a[0]), 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NI; i++) begin
        op = int'($urandom_range(0, 3));
        lg = int'($urandom_range(0, 3));
        sx = (op == 2) ? 0 : int'($urandom_range(0, 1));
        a  = int'($urandom_range(0, 'h1FFFF));
        if ($urandom_range(0, 3) != 0) a = a & ~((1 << lg) - 1);
        do_cmd(i, op, lg, sx, a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ej32_lsu_gen.md
Name: ej32_lsu_gen

Overview:
Parametrised load/store sequencer for the eJ32 core. It generalises the byte-serial array load/store path to a configurable memory bus width (1/2/4 bytes per beat), configurable access size, and sign/zero extension. It adds circular input/output console buffers with wrap-around and a valid/ready command handshake. It sits between the eJ32 control/decoder and the memory bus arbiter; the decoder issues one command per iaload/saload/baload/iastore/sastore/bastore/get/put.

Parameters:
DSZ, 32, data width in bits (TOS / result width)
ASZ, 17, byte address width
BUS_BYTES, 1, memory bus bytes per beat; legal values 1, 2, 4
TIB, 'h1000, input ring buffer base address
OBUF, 'h1400, output ring buffer base address
BUF_LG, 10, log2 of ring buffer size in bytes (ring size 1024)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
req_valid  in  1  command valid
req_ready  out  1  high only in IDLE
req_op  in  2  0 LOAD, 1 STORE, 2 GET, 3 PUT
req_lgsz  in  2  log2 access bytes: 0=1, 1=2, 2=4, 3 illegal (LOAD/STORE only)
req_sext  in  1  sign-extend loads
req_addr  in  ASZ  byte address (LOAD/STORE)
req_wdata  in  DSZ  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  valid with rsp_valid; misaligned or illegal size
rsp_rdata  out  DSZ  extended load/GET result; 0 for stores
mem_addr  out  ASZ  beat address, BUS_BYTES-aligned
mem_en  out  1  beat strobe
mem_we  out  1  write strobe
mem_be  out  BUS_BYTES  byte enables; bit BUS_BYTES-1 = lowest address
mem_wdata  out  8*BUS_BYTES  write data, big-endian
mem_rdata  in  8*BUS_BYTES  read data, valid exactly one cycle after a read beat
ibuf_ptr, obuf_ptr  out  ASZ  current ring pointers

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_en=0; mem_we=0; mem_be=0; ibuf_ptr=TIB; obuf_ptr=OBUF. A reset mid-command aborts it: no rsp, no further beats, and mem_we is low from the next cycle.
- FSM: IDLE -> BEAT -> (LOAD/GET only) DRAIN -> RESP -> IDLE. An illegal command goes IDLE -> RESP with err set.
- Accept: req_valid&&req_ready at edge N. The command is latched and the ring pointer is snapshotted for GET/PUT. req_valid while busy is ignored.
- Effective size: GET/PUT is always 1 byte at ibuf_ptr/obuf_ptr.
- Beats: nb = max(1, 2^lgsz / BUS_BYTES). Beat k (k=0..nb-1) is driven in cycle N+1+k at the aligned address + k*BUS_BYTES.
- Byte enables: mem_be covers only the addressed bytes when the access is narrower than the bus.
- Endianness: big-endian throughout. The lowest address carries the most significant byte.
- Load data: mem_rdata from beat k is merged in cycle N+2+k, shifting left by the enabled byte count. The final value is zero- or sign-extended from 8*2^lgsz bits to DSZ.
- Load latency: rsp_valid in cycle N+2+nb.
- Store latency: rsp_valid in cycle N+1+nb. Store data bytes are taken MSB-first from the low 8*2^lgsz bits of req_wdata.
- Errors:
  - lgsz=3 gives rsp_err.
  - req_addr not a multiple of 2^lgsz gives rsp_err.
  - In both cases there are zero mem beats, rsp_valid comes in N+1, and rsp_rdata=0.
- Ring pointers advance by exactly 1 in the RESP cycle of a successful GET/PUT. They wrap from base+2^BUF_LG-1 back to base; the upper ASZ-BUF_LG bits of the pointer are fixed to the base.
- Width rules: the address adder is ASZ bits and wraps modulo 2^ASZ. rsp_rdata is DSZ bits.

Decomposition:
- Package ej32_pkg additions:
  - lsu_op_t enum (LOAD, STORE, GET, PUT)
  - lsu_state_t enum (IDLE, BEAT, DRAIN, RESP)
  - function nbeats(lgsz, BUS_BYTES)
  - function be_mask(addr, lgsz, BUS_BYTES)
- One sub-module, ej32_ring_ptr: a parametrised base/BUF_LG wrapping pointer with inc input. It is instantiated twice (input and output buffers).

Test Plan:
- BUS_BYTES=1, LOAD lgsz=2 sext=0 addr 0x0100, mem bytes 0x12,0x34,0x56,0x78 -> mem_addr 0x100..0x103 on consecutive cycles; rsp_rdata=0x12345678 at N+6.
- BUS_BYTES=4, LOAD lgsz=1 sext=1 addr 0x0202, mem_rdata 0x0000_8001 -> one beat at 0x200 with mem_be=4'b0011; rsp_rdata=0xFFFF8001 at N+3.
- BUS_BYTES=2, STORE lgsz=2 wdata 0xDEADBEEF addr 0x0300 -> beats (0x300, 0xDEAD, be=11), (0x302, 0xBEEF, be=11); rsp_valid at N+3, rsp_err=0.
- LOAD lgsz=2 addr 0x0101, and separately lgsz=3 -> rsp_err=1 at N+1; mem_en never asserted.
- BUF_LG=2, five PUTs of 0x41..0x45 -> mem_addr 0x1400, 0x1401, 0x1402, 0x1403, 0x1400; obuf_ptr returns to 0x1400 after the fourth PUT.
- Assert rst=0 during beat 1 of a 4-beat store -> next cycle mem_en=0, mem_we=0, state IDLE, no rsp_valid, pointers back at TIB/OBUF.
